// File: rtl/jzjcoref_wb_pkg.sv
// Shared definitions for the register-file writeback path.
//   wb_source_t  : selects which unit drives the rd input mux
//   wb_state_t   : writeback sequencer states
//   REG_ZERO     : architectural zero register index (never written)
//   source_onehot: maps a source to its {branch, imm, alu, mem} enable vector
package jzjcoref_wb_pkg;

   typedef enum logic [1:0] {
      WB_MEM    = 2'd0,
      WB_ALU    = 2'd1,
      WB_IMM    = 2'd2,
      WB_BRANCH = 2'd3
   } wb_source_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      WRITE    = 2'd2
   } wb_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Bit order matches {branch, imm, alu, mem}, i.e. bit index == source code.
   function automatic logic [3:0] source_onehot(input wb_source_t src);
      return 4'b0001 << src;
   endfunction

endpackage

// File: rtl/rd_writeback_controller.sv
// Writeback sequencer between decode/control and the rd mux / register file.
// Accepts one retiring instruction at a time, runs a bounded load handshake
// for memory sources, then issues a single-cycle register-file write.
//
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   instrValid, wbSource,
//   writesRd, rdAddrIn           : instruction presented for writeback
//   memReadValid                 : load data valid (only observed in MEM_WAIT)
//   ready                        : controller idle, instruction may be accepted
//   memReadRequest               : level request for load data
//   memoryOutputEnable,
//   aluOutputEnable,
//   immediateFormerOutputEnable,
//   branchALUOutputEnable        : one-hot-or-zero rd mux enables
//   rdWriteEnable, rdAddrOut     : register-file write strobe and index
//   instrDone                    : one-cycle retire pulse
//   memTimeout                   : one-cycle pulse when a load is abandoned
module rd_writeback_controller
   import jzjcoref_wb_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       instrValid,
   input  logic [1:0] wbSource,
   input  logic       writesRd,
   input  logic [4:0] rdAddrIn,
   input  logic       memReadValid,
   output logic       ready,
   output logic       memReadRequest,
   output logic       memoryOutputEnable,
   output logic       aluOutputEnable,
   output logic       immediateFormerOutputEnable,
   output logic       branchALUOutputEnable,
   output logic       rdWriteEnable,
   output logic [4:0] rdAddrOut,
   output logic       instrDone,
   output logic       memTimeout
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] COUNT_MAX  = CW'(MEM_TIMEOUT);
   // The counter holds the number of completed wait cycles, so the cycle in
   // which it equals MEM_TIMEOUT-1 is the last one a valid can rescue.
   localparam logic [CW-1:0] COUNT_LAST = CW'(MEM_TIMEOUT - 1);

   wb_state_t      state_reg, state_next;
   wb_source_t     source_reg, source_next;
   logic           writes_rd_reg, writes_rd_next;
   logic [4:0]     rd_addr_reg, rd_addr_next;
   logic [CW-1:0]  count_reg, count_next;
   logic           timeout_reg, timeout_next;
   logic [3:0]     enable_vec;

   always_comb begin
      state_next     = state_reg;
      source_next    = source_reg;
      writes_rd_next = writes_rd_reg;
      rd_addr_next   = rd_addr_reg;
      count_next     = count_reg;
      timeout_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (instrValid) begin
               source_next    = wb_source_t'(wbSource);
               writes_rd_next = writesRd;
               rd_addr_next   = rdAddrIn;
               if (wb_source_t'(wbSource) == WB_MEM) begin
                  state_next = MEM_WAIT;
                  count_next = '0;
               end else begin
                  state_next = WRITE;
               end
            end
         end
         MEM_WAIT: begin
            // Saturate rather than wrap so a stale count can never look fresh.
            count_next = (count_reg == COUNT_MAX) ? count_reg : count_reg + CW'(1);
            // Valid is tested first so it wins over a simultaneous timeout.
            if (memReadValid) begin
               state_next = WRITE;
            end else if (count_reg >= COUNT_LAST) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end
         end
         WRITE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         source_reg    <= WB_MEM;
         writes_rd_reg <= 1'b0;
         rd_addr_reg   <= REG_ZERO;
         count_reg     <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         source_reg    <= source_next;
         writes_rd_reg <= writes_rd_next;
         rd_addr_reg   <= rd_addr_next;
         count_reg     <= count_next;
         timeout_reg   <= timeout_next;
      end
   end

   // Every output comes from registers only; the mux sees all-zero enables
   // outside WRITE so its output is zero while idle.
   assign enable_vec = (state_reg == WRITE) ? source_onehot(source_reg) : 4'b0000;

   assign ready                       = (state_reg == IDLE);
   assign memReadRequest              = (state_reg == MEM_WAIT);
   assign memoryOutputEnable          = enable_vec[0];
   assign aluOutputEnable             = enable_vec[1];
   assign immediateFormerOutputEnable = enable_vec[2];
   assign branchALUOutputEnable       = enable_vec[3];
   assign rdWriteEnable               = (state_reg == WRITE) && writes_rd_reg &&
                                        (rd_addr_reg != REG_ZERO);
   assign rdAddrOut                   = rd_addr_reg;
   assign instrDone                   = (state_reg == WRITE);
   assign memTimeout                  = timeout_reg;

endmodule
